// File: rtl/pqsdn_ram_rd_ctrl.sv
// Read-side lookup engine for pqsdn_ram: issues RAM reads, absorbs the 1-cycle latency and queues
// tagged responses in a credit-protected FIFO. Define PQSDN_RD_BYPASS_EN to forward hazarding writes.
module pqsdn_ram_rd_ctrl #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 10,
    parameter int TAG_W     = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [ADDR_W-1:0]            req_addr_i,
    input  logic [TAG_W-1:0]             req_tag_i,
    output logic                         ram_rden_o,
    output logic [ADDR_W-1:0]            ram_rdaddr_o,
    input  logic [DATA_W-1:0]            ram_rddata_i,
    input  logic                         wr_en_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [DATA_W-1:0]            rsp_data_o,
    output logic [TAG_W-1:0]             rsp_tag_o,
    output logic [$clog2(RSP_DEPTH):0]   occupancy_o
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic              ready_q;
    logic              accept;
    logic              infl_q;
    logic [TAG_W-1:0]  infl_tag_q;
    logic [DATA_W-1:0] land_data;

    rsp_t              mem_q [RSP_DEPTH];
    rsp_t              head;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  occ_q;
    logic [CNT_W-1:0]  occ_next;
    logic              push;
    logic              pop;
    logic              rsp_valid;

    // Issue: the RAM read port is driven straight from the accepted request.
    assign accept       = req_valid_i & ready_q;
    assign req_ready_o  = ready_q;
    assign ram_rden_o   = accept;
    assign ram_rdaddr_o = accept ? req_addr_i : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q     <= 1'b0;
            infl_tag_q <= '0;
        end else begin
            infl_q <= accept;
            if (accept) begin
                infl_tag_q <= req_tag_i;
            end
        end
    end

    assign rsp_valid = (count_q != '0);
    assign push      = infl_q;
    assign pop       = rsp_valid & rsp_ready_i;

    // NOTE: combinational blocks assign a default first so no path leaves a variable held (no latch).
    always_comb begin
        count_next = count_q;
        if (push && !pop) begin
            count_next = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    // Credit counts the read in flight, so the FIFO always has room for the word that lands next.
    assign occ_next = count_next + CNT_W'(accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            occ_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_next;
            occ_q   <= occ_next;
            ready_q <= (occ_next < CNT_W'(RSP_DEPTH));
        end
    end

    // NOTE: FIFO storage is not reset; entries are only observable behind rsp_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{tag: infl_tag_q, data: land_data};
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign rsp_valid_o = rsp_valid;
    assign rsp_data_o  = rsp_valid ? head.data : '0;
    assign rsp_tag_o   = rsp_valid ? head.tag : '0;
    assign occupancy_o = occ_q;

`ifdef PQSDN_RD_BYPASS_EN
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic              byp_hit_q;
    logic [DATA_W-1:0] byp_data_q;

    // The write presented this cycle is newer than the one still queued in the RAM write register.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        if (wr_en_i && (wr_addr_i == req_addr_i)) begin
            byp_hit  = 1'b1;
            byp_data = wr_data_i;
        end else if (wr_en_q && (wr_addr_q == req_addr_i)) begin
            byp_hit  = 1'b1;
            byp_data = wr_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_i;
            wr_addr_q <= wr_addr_i;
            wr_data_q <= wr_data_i;
            byp_hit_q <= accept & byp_hit;
            if (accept) begin
                byp_data_q <= byp_data;
            end
        end
    end

    assign land_data = byp_hit_q ? byp_data_q : ram_rddata_i;
`else
    logic unused_wr;

    // Without forwarding the snoop port is deliberately ignored.
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
    assign land_data = ram_rddata_i;
`endif

endmodule

// File: tb/tb_pqsdn_ram_rd_ctrl.sv
// Directed bench for pqsdn_ram_rd_ctrl with a registered-write, 1-cycle-read RAM model.
// Build with PQSDN_RD_BYPASS_EN defined to check the forwarding variant.
module tb_pqsdn_ram_rd_ctrl;

    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 10;
    localparam int TAG_W     = 8;
    localparam int RSP_DEPTH = 4;

`ifdef PQSDN_RD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic [TAG_W-1:0]  req_tag_i;
    logic              ram_rden_o;
    logic [ADDR_W-1:0] ram_rdaddr_o;
    logic [DATA_W-1:0] ram_rddata_i;
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic [TAG_W-1:0]  rsp_tag_o;
    logic [2:0]        occupancy_o;

    pqsdn_ram_rd_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .TAG_W     (TAG_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_tag_i    (req_tag_i),
        .ram_rden_o   (ram_rden_o),
        .ram_rdaddr_o (ram_rdaddr_o),
        .ram_rddata_i (ram_rddata_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .rsp_tag_o    (rsp_tag_o),
        .occupancy_o  (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write port registered (array updated one cycle after presentation), read latency 1.
    logic [DATA_W-1:0] ram [1024];
    logic              wq_en;
    logic [ADDR_W-1:0] wq_addr;
    logic [DATA_W-1:0] wq_data;

    always @(posedge clk) begin
        if (ram_rden_o) ram_rddata_i <= ram[ram_rdaddr_o];
        if (wq_en === 1'b1) ram[wq_addr] <= wq_data;
        wq_en   <= wr_en_i;
        wq_addr <= wr_addr_i;
        wq_data <= wr_data_i;
    end

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    logic [TAG_W-1:0]  mon_tag [$];
    logic [DATA_W-1:0] mon_data [$];
    int                mon_cyc [$];

    always @(negedge clk) begin
        if (rst_n && rsp_valid_o && rsp_ready_i) begin
            mon_tag.push_back(rsp_tag_o);
            mon_data.push_back(rsp_data_o);
            mon_cyc.push_back(cyc);
        end
    end

    int n_checks;
    int n_pass;
    logic [TAG_W-1:0]  exp_tag [$];
    logic [DATA_W-1:0] exp_data [$];
    int rd_idx;
    int last_issue;
    int first_issue;
    int base;
    int acc;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'h0123_4567_0000_0000 | 64'(i * 257);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        wr_en_i = 1'b1; wr_addr_i = addr; wr_data_i = data;
        @(posedge clk); #1;
        wr_en_i = 1'b0;
    endtask

    task automatic send(input logic [ADDR_W-1:0] addr, input logic [TAG_W-1:0] tag,
                        input logic [DATA_W-1:0] data);
        int n = 0;
        req_valid_i = 1'b1; req_addr_i = addr; req_tag_i = tag;
        @(negedge clk);
        while (!req_ready_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (req_ready_o) begin
            exp_tag.push_back(tag);
            exp_data.push_back(data);
            last_issue = cyc;
        end else begin
            check("send_ready", 64'(req_ready_o), 64'd1);
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic check_rsps(input string name);
        int n = 0;
        int got;
        while ((mon_tag.size() - rd_idx) < exp_tag.size() && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        got = mon_tag.size() - rd_idx;
        check({name, "_count"}, 64'(got), 64'(exp_tag.size()));
        for (int i = 0; i < exp_tag.size(); i++) begin
            if (rd_idx + i < mon_tag.size()) begin
                check($sformatf("%s_tag%0d", name, i), 64'(mon_tag[rd_idx + i]), 64'(exp_tag[i]));
                check($sformatf("%s_data%0d", name, i), mon_data[rd_idx + i], exp_data[i]);
            end
        end
        rd_idx = mon_tag.size();
        exp_tag.delete();
        exp_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 10'd3; req_tag_i = 8'h00;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        rsp_ready_i = 1'b0;

        // Reset state, with a request held valid to confirm nothing is issued.
        #12;
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        check("rst_ram_rden", 64'(ram_rden_o), 64'd0);
        check("rst_ram_rdaddr", 64'(ram_rdaddr_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rsp_data", rsp_data_o, 64'd0);
        check("rst_rsp_tag", 64'(rsp_tag_o), 64'd0);
        check("rst_occupancy", 64'(occupancy_o), 64'd0);
        req_valid_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(req_ready_o), 64'd1);

        // 1: single lookup, latency exactly 2.
        write_word(10'd5, 64'hA5);
        idle(3);
        rsp_ready_i = 1'b1;
        base = rd_idx;
        send(10'd5, 8'h11, 64'hA5);
        check_rsps("single");
        if (mon_cyc.size() > base) check("single_latency", 64'(mon_cyc[base] - last_issue), 64'd2);

        // 2: streaming 16 back-to-back lookups.
        for (int i = 0; i < 16; i++) write_word(10'(i), pat(i));
        idle(3);
        base = rd_idx;
        for (int i = 0; i < 16; i++) begin
            send(10'(i), 8'(8'h20 + i), pat(i));
            if (i == 0) first_issue = last_issue;
        end
        check("stream_issue_span", 64'(last_issue - first_issue), 64'd15);
        check_rsps("stream");
        if (mon_cyc.size() >= base + 16)
            check("stream_rsp_span", 64'(mon_cyc[base + 15] - mon_cyc[base]), 64'd15);

        // 3: backpressure - only 4 credits with responses blocked.
        rsp_ready_i = 1'b0;
        acc = 0;
        req_valid_i = 1'b1; req_addr_i = 10'd0; req_tag_i = 8'h30;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_ready_o) begin
                exp_tag.push_back(8'(8'h30 + acc));
                exp_data.push_back(pat(acc));
                acc++;
            end
            @(posedge clk); #1;
            req_addr_i = 10'(acc); req_tag_i = 8'(8'h30 + acc);
        end
        req_valid_i = 1'b0;
        check("bp_accepts", 64'(acc), 64'd4);
        @(negedge clk);
        check("bp_ready_low", 64'(req_ready_o), 64'd0);
        check("bp_occupancy", 64'(occupancy_o), 64'd4);
        check("bp_head_tag", 64'(rsp_tag_o), 64'h30);
        @(posedge clk); #1;
        rsp_ready_i = 1'b1;
        for (int i = 4; i < 8; i++) send(10'(i), 8'(8'h30 + i), pat(i));
        check_rsps("bp");

        // 4: read-after-write hazard window.
        write_word(10'd7, 64'd1);
        idle(3);
        wr_en_i = 1'b1; wr_addr_i = 10'd7; wr_data_i = 64'd2;
        req_valid_i = 1'b1; req_addr_i = 10'd7; req_tag_i = 8'h41;
        @(negedge clk); check("raw_rdy_w", 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;
        wr_en_i = 1'b0; req_tag_i = 8'h42;
        @(negedge clk); check("raw_rdy_w1", 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;
        req_tag_i = 8'h43;
        @(negedge clk); check("raw_rdy_w2", 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        exp_tag.push_back(8'h41); exp_data.push_back(BYPASS ? 64'd2 : 64'd1);
        exp_tag.push_back(8'h42); exp_data.push_back(BYPASS ? 64'd2 : 64'd1);
        exp_tag.push_back(8'h43); exp_data.push_back(64'd2);
        check_rsps("raw");

        // 5: two writes to one address, read alongside the second.
        write_word(10'd9, 64'h90);
        idle(3);
        wr_en_i = 1'b1; wr_addr_i = 10'd9; wr_data_i = 64'd3;
        @(posedge clk); #1;
        wr_data_i = 64'd4;
        req_valid_i = 1'b1; req_addr_i = 10'd9; req_tag_i = 8'h51;
        @(negedge clk); check("dw_rdy_w1", 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;
        wr_en_i = 1'b0; req_valid_i = 1'b0;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_tag_i = 8'h52;
        @(negedge clk); check("dw_rdy_w3", 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        exp_tag.push_back(8'h51); exp_data.push_back(BYPASS ? 64'd4 : 64'h90);
        exp_tag.push_back(8'h52); exp_data.push_back(64'd4);
        check_rsps("dw");

        // 6: reset with 3 responses queued and 1 read in flight.
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(10'(i), 8'(8'h60 + i), pat(i));
        check("mid_occupancy", 64'(occupancy_o), 64'd4);
        check("mid_rsp_valid", 64'(rsp_valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("mid_rst_occupancy", 64'(occupancy_o), 64'd0);
        check("mid_rst_ready", 64'(req_ready_o), 64'd0);
        exp_tag.delete();
        exp_data.delete();
        rd_idx = mon_tag.size();
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_occupancy", 64'(occupancy_o), 64'd0);
        check("rel_rsp_valid", 64'(rsp_valid_o), 64'd0);
        rsp_ready_i = 1'b1;
        base = rd_idx;
        send(10'd5, 8'h6A, pat(5));
        check_rsps("post_rst");
        if (mon_cyc.size() > base) check("post_rst_latency", 64'(mon_cyc[base] - last_issue), 64'd2);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
